// File: rtl/bottle_tally.sv
`default_nettype none
// ============================================================================
// Module   : bottle_tally
// Purpose  : Counts completed bottles (BCD) against a target, raises allFull.
//            Optional 3-digit pill total when BOTTLE_TALLY_TOTAL_EN is defined.
// Revision : 1.0
// ============================================================================
module bottle_tally (
    input  logic       CLK,
    input  logic       RST,
    input  logic       isWork,
    input  logic       clear,
    input  logic [3:0] cntL,
    input  logic [3:0] cntH,
    input  logic [3:0] maxL,
    input  logic [3:0] maxH,
    input  logic [3:0] tgtL,
    input  logic [3:0] tgtH,
    output logic       allFull,
    output logic       bottleDone,
    output logic [3:0] bottleL,
    output logic [3:0] bottleH,
    output logic [3:0] totL,
    output logic [3:0] totM,
    output logic [3:0] totH
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_RUN      = 2'd1;
    localparam logic [1:0] S_FULL     = 2'd2;
    localparam logic [7:0] C_BCD2_MAX = 8'h99;

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic [7:0] prev_q;
    logic [7:0] cur_q;
    logic       prime_q;
    logic [7:0] bot_q;
    logic [7:0] bot_d;
    logic       done_q;
    logic       done_d;

    logic [7:0] w_cnt;
    logic [7:0] w_max;
    logic [7:0] w_tgt;
    logic       w_run;
    logic       w_bot_ev;
    logic       w_bot_cnt;

    function automatic logic [3:0] f_dig_inc(input logic [3:0] d);
        return (d >= 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    function automatic logic [7:0] f_bcd2_inc(input logic [7:0] v);
        logic [7:0] r;
        r[3:0] = f_dig_inc(v[3:0]);
        r[7:4] = (v[3:0] >= 4'd9) ? f_dig_inc(v[7:4]) : v[7:4];
        return r;
    endfunction

    assign w_cnt = {cntH, cntL};
    assign w_max = {maxH, maxL};
    assign w_tgt = {tgtH, tgtL};
    assign w_run = (state_q == S_RUN);

    // After reset/clear the first sample fills both history slots, so it can
    // never pair with a stale value and look like an event.
    always_ff @(posedge CLK) begin
        if (RST || clear) begin
            prev_q  <= 8'h00;
            cur_q   <= 8'h00;
            prime_q <= 1'b1;
        end else if (prime_q) begin
            prev_q  <= w_cnt;
            cur_q   <= w_cnt;
            prime_q <= 1'b0;
        end else begin
            prev_q  <= cur_q;
            cur_q   <= w_cnt;
        end
    end

    assign w_bot_ev  = (w_max != 8'h00) && (prev_q == w_max) && (cur_q == 8'h00);
    assign w_bot_cnt = w_run && w_bot_ev;

    always_comb begin
        bot_d  = bot_q;
        done_d = 1'b0;
        if (w_bot_cnt) begin
            done_d = 1'b1;
            if (bot_q != C_BCD2_MAX) begin
                bot_d = f_bcd2_inc(bot_q);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST || clear) begin
            bot_q  <= 8'h00;
            done_q <= 1'b0;
        end else begin
            bot_q  <= bot_d;
            done_q <= done_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (isWork) begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    // Comparing the incremented count lets allFull rise with the count.
                    if (w_bot_cnt && (w_tgt != 8'h00) && (bot_d == w_tgt)) begin
                        state_d = S_FULL;
                    end else if (!isWork) begin
                        state_d = S_IDLE;
                    end
                end
                S_FULL:  state_d = S_FULL;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        allFull = (state_q == S_FULL);
    end

    assign bottleDone = done_q;
    assign bottleL    = bot_q[3:0];
    assign bottleH    = bot_q[7:4];

`ifdef BOTTLE_TALLY_TOTAL_EN
    localparam logic [11:0] C_BCD3_MAX = 12'h999;

    logic [11:0] tot_q;
    logic [11:0] tot_d;
    logic        w_step_ev;

    // 99 -> 00 is a bottle wrap, not a step.
    assign w_step_ev = (prev_q != C_BCD2_MAX) && (cur_q == f_bcd2_inc(prev_q));

    always_comb begin
        tot_d = tot_q;
        if (w_run && w_step_ev && (tot_q != C_BCD3_MAX)) begin
            tot_d[3:0] = f_dig_inc(tot_q[3:0]);
            if (tot_q[3:0] >= 4'd9) begin
                tot_d[7:4] = f_dig_inc(tot_q[7:4]);
                if (tot_q[7:4] >= 4'd9) begin
                    tot_d[11:8] = f_dig_inc(tot_q[11:8]);
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST || clear) begin
            tot_q <= 12'h000;
        end else begin
            tot_q <= tot_d;
        end
    end

    assign totL = tot_q[3:0];
    assign totM = tot_q[7:4];
    assign totH = tot_q[11:8];
`else
    assign totL = 4'd0;
    assign totM = 4'd0;
    assign totH = 4'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bottle_tally.sv
`default_nettype none
// Testbench for bottle_tally: queue-based decimal reference model compared every
// cycle, plus directed scenarios with hand-computed expectations and a random phase.
module tb_bottle_tally;

`ifdef BOTTLE_TALLY_TOTAL_EN
    localparam bit TOT_EN = 1'b1;
`else
    localparam bit TOT_EN = 1'b0;
`endif

    logic       CLK;
    logic       RST;
    logic       isWork;
    logic       clear;
    logic [3:0] cntL, cntH, maxL, maxH, tgtL, tgtH;
    logic       allFull, bottleDone;
    logic [3:0] bottleL, bottleH, totL, totM, totH;

    int checks   = 0;
    int failures = 0;

    bottle_tally dut (
        .CLK       (CLK),
        .RST       (RST),
        .isWork    (isWork),
        .clear     (clear),
        .cntL      (cntL),
        .cntH      (cntH),
        .maxL      (maxL),
        .maxH      (maxH),
        .tgtL      (tgtL),
        .tgtH      (tgtH),
        .allFull   (allFull),
        .bottleDone(bottleDone),
        .bottleL   (bottleL),
        .bottleH   (bottleH),
        .totL      (totL),
        .totM      (totM),
        .totH      (totH)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- reference model (decimal arithmetic) ----------------
    // mode: 0 idle, 1 running, 2 full
    int m_mode  = 0;
    int m_bot   = 0;
    int m_tot   = 0;
    bit m_done  = 1'b0;
    bit armed   = 1'b0;
    int hist[$];
    int s, mx, tg, nb;
    bit bev, sev, run;

    always @(posedge CLK) begin
        s  = int'(cntH) * 10 + int'(cntL);
        mx = int'(maxH) * 10 + int'(maxL);
        tg = int'(tgtH) * 10 + int'(tgtL);
        if (RST || clear) begin
            m_mode = 0;
            m_bot  = 0;
            m_tot  = 0;
            m_done = 1'b0;
            hist.delete();
            if (RST) armed = 1'b1;
        end else begin
            bev = 1'b0;
            sev = 1'b0;
            if (hist.size() >= 2) begin
                bev = (mx != 0) && (hist[0] == mx) && (hist[1] == 0);
                sev = (hist[1] == hist[0] + 1);
            end
            run    = (m_mode == 1);
            m_done = run && bev;
            nb     = m_bot;
            if (run && bev) nb = (m_bot < 99) ? m_bot + 1 : 99;
            if (run && sev && m_tot < 999) m_tot = m_tot + 1;
            if (m_mode == 0) begin
                if (isWork) m_mode = 1;
            end else if (m_mode == 1) begin
                if (bev && tg != 0 && nb == tg) m_mode = 2;
                else if (!isWork) m_mode = 0;
            end
            m_bot = nb;
            hist.push_back(s);
            if (hist.size() > 2) void'(hist.pop_front());
        end
    end

    logic [21:0] exp_v, act_v;
    int          et;

    always @(negedge CLK) begin
        if (armed) begin
            et    = TOT_EN ? m_tot : 0;
            exp_v = {m_mode == 2, m_done, 4'(m_bot / 10), 4'(m_bot % 10),
                     4'(et / 100), 4'((et / 10) % 10), 4'(et % 10)};
            act_v = {allFull, bottleDone, bottleH, bottleL, totH, totM, totL};
            checks++;
            if (act_v !== exp_v) begin
                failures++;
                $display("FAIL cycle_compare t=%0t: got full=%b done=%b bot=%h tot=%h, expected full=%b done=%b bot=%h tot=%h",
                         $time, act_v[21], act_v[20], act_v[19:12], act_v[11:0],
                         exp_v[21], exp_v[20], exp_v[19:12], exp_v[11:0]);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    int maxv = 0;

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic set_cnt(input int v);
        cntH = 4'(v / 10);
        cntL = 4'(v % 10);
    endtask

    task automatic set_max(input int v);
        maxv = v;
        maxH = 4'(v / 10);
        maxL = 4'(v % 10);
    endtask

    task automatic set_tgt(input int v);
        tgtH = 4'(v / 10);
        tgtL = 4'(v % 10);
    endtask

    task automatic bottle(input int m);
        for (int i = 1; i <= m; i++) begin
            set_cnt(i);
            tick(1);
        end
        set_cnt(0);
        tick(1);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
    endtask

    int bot_v, tot_v, r, r2, walk;

    always_comb begin
        bot_v = int'({bottleH, bottleL});
        tot_v = int'({totH, totM, totL});
    end

    initial begin
        RST = 1'b1; clear = 1'b0; isWork = 1'b0;
        set_cnt(0); set_max(0); set_tgt(0);
        tick(2);
        chk("reset_allFull", int'(allFull), 0);
        chk("reset_done", int'(bottleDone), 0);
        chk("reset_bottle", bot_v, 'h00);
        chk("reset_total", tot_v, 'h000);

        // Capacity 05, target 03
        RST = 1'b0; set_max(5); set_tgt(3); isWork = 1'b1;
        tick(2);
        repeat (3) bottle(5);
        tick(3);
        chk("s1_bottle", bot_v, 'h03);
        chk("s1_allFull", int'(allFull), 1);
        chk("s1_total", tot_v, TOT_EN ? 'h015 : 'h000);

        // FULL holds against further bottles
        bottle(5);
        tick(3);
        chk("full_bottle", bot_v, 'h03);
        chk("full_total", tot_v, TOT_EN ? 'h015 : 'h000);
        chk("full_allFull", int'(allFull), 1);
        do_clear();
        chk("clr_allFull", int'(allFull), 0);
        chk("clr_bottle", bot_v, 'h00);
        chk("clr_total", tot_v, 'h000);

        // Saturation: unlimited target, capacity 01, 120 bottles
        set_tgt(0); set_max(1);
        tick(3);
        repeat (120) bottle(1);
        tick(3);
        chk("sat_bottle", bot_v, 'h99);
        chk("sat_allFull", int'(allFull), 0);
        chk("sat_total", tot_v, TOT_EN ? 'h120 : 'h000);

        // isWork low: nothing counted
        do_clear();
        isWork = 1'b0; set_max(5);
        tick(2);
        bottle(5);
        tick(3);
        chk("idle_bottle", bot_v, 'h00);
        chk("idle_total", tot_v, 'h000);

        // Capacity 00 disables bottle detection; steps still total
        isWork = 1'b1; set_max(0);
        tick(3);
        bottle(5);
        tick(3);
        chk("cap0_bottle", bot_v, 'h00);
        chk("cap0_total", tot_v, TOT_EN ? 'h005 : 'h000);

        // Settings reload 07 -> 00 with capacity 09 is not a bottle
        set_max(9);
        for (int i = 1; i <= 7; i++) begin
            set_cnt(i);
            tick(1);
        end
        set_cnt(0);
        tick(3);
        chk("reload_bottle", bot_v, 'h00);
        chk("reload_total", tot_v, TOT_EN ? 'h012 : 'h000);

        // clear on the cycle the bottle event would register
        do_clear();
        set_max(5); set_tgt(0);
        tick(3);
        for (int i = 1; i <= 5; i++) begin
            set_cnt(i);
            tick(1);
        end
        set_cnt(0);
        tick(1);
        clear = 1'b1;
        tick(1);
        chk("prio_bottle", bot_v, 'h00);
        chk("prio_done", int'(bottleDone), 0);
        clear = 1'b0;

        // RST mid-run at 42 bottles
        set_max(1);
        tick(3);
        repeat (42) bottle(1);
        tick(3);
        chk("pre_rst_bottle", bot_v, 'h42);
        RST = 1'b1;
        tick(1);
        chk("rst_bottle", bot_v, 'h00);
        chk("rst_done", int'(bottleDone), 0);
        chk("rst_allFull", int'(allFull), 0);
        chk("rst_total", tot_v, 'h000);
        RST = 1'b0;
        tick(2);

        // Randomised phase
        walk = 0;
        set_cnt(0);
        for (int k = 0; k < 4000; k++) begin
            if (k % 400 == 0) begin
                set_max(int'($urandom_range(0, 9)));
                set_tgt(int'($urandom_range(0, 5)));
            end
            r      = int'($urandom_range(0, 999));
            RST    = (r < 3);
            clear  = (r >= 3 && r < 15);
            if (r >= 15 && r < 40) isWork = ~isWork;
            else if (r >= 40 && r < 60) isWork = 1'b1;
            r2 = int'($urandom_range(0, 99));
            if (r2 < 75) walk = (walk < maxv) ? walk + 1 : 0;
            else if (r2 < 85) walk = int'($urandom_range(0, 99));
            set_cnt(walk);
            tick(1);
        end
        RST = 1'b0; clear = 1'b0;
        tick(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
